// File: rtl/prog_loader.sv
// prog_loader: byte-stream command parser that loads words into program memory
// and controls the CPU core reset line.
// Ports:
//   clk, rst (async, active-high)
//   inData/inValid/inReady : command and payload byte stream, accepted when valid & ready
//   memWe/memAddr/memData  : program-memory write port (one-cycle strobe, registered addr/data)
//   coreRst_n              : core reset, 0 holds the core, 1 lets it run
//   busy                   : loader is in the middle of a frame or write
//   error                  : sticky protocol error, cleared by HALT or reset
module prog_loader #(
  parameter int ADDR_WIDTH = 9,
  parameter int INST_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            inData,
  input  logic                  inValid,
  output logic                  inReady,
  output logic                  memWe,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [INST_WIDTH-1:0] memData,
  output logic                  coreRst_n,
  output logic                  busy,
  output logic                  error
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR_HI = 3'd1;
  localparam logic [2:0] S_ADDR_LO = 3'd2;
  localparam logic [2:0] S_DATA_HI = 3'd3;
  localparam logic [2:0] S_DATA_LO = 3'd4;
  localparam logic [2:0] S_WRITE   = 3'd5;

  localparam logic [7:0] CMD_LOAD_ADDR = 8'h01;
  localparam logic [7:0] CMD_WRITE     = 8'h02;
  localparam logic [7:0] CMD_RUN       = 8'h03;
  localparam logic [7:0] CMD_HALT      = 8'h04;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [ADDR_WIDTH-9:0] addr_hi;
  logic [INST_WIDTH-9:0] data_hi;
  logic                  accept;

  // The only cycle a byte cannot be taken is the single write cycle.
  assign inReady = (state != S_WRITE);
  assign accept  = inValid & inReady;
  assign memWe   = (state == S_WRITE);
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      addr_cnt  <= '0;
      addr_hi   <= '0;
      data_hi   <= '0;
      memAddr   <= '0;
      memData   <= '0;
      coreRst_n <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (inData)
              // Loading is only legal while the core is held; otherwise the
              // command is swallowed and flagged so the core's program is safe.
              CMD_LOAD_ADDR: begin
                if (coreRst_n) error <= 1'b1;
                else           state <= S_ADDR_HI;
              end
              CMD_WRITE: begin
                if (coreRst_n) error <= 1'b1;
                else           state <= S_DATA_HI;
              end
              CMD_RUN:  coreRst_n <= 1'b1;
              CMD_HALT: begin
                coreRst_n <= 1'b0;
                error     <= 1'b0;
              end
              default:  error <= 1'b1;
            endcase
          end
        end
        S_ADDR_HI: begin
          if (accept) begin
            addr_hi <= inData[ADDR_WIDTH-9:0];
            state   <= S_ADDR_LO;
          end
        end
        S_ADDR_LO: begin
          if (accept) begin
            addr_cnt <= {addr_hi, inData};
            state    <= S_IDLE;
          end
        end
        S_DATA_HI: begin
          if (accept) begin
            data_hi <= inData[INST_WIDTH-9:0];
            state   <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          // Address and word are registered here so they are stable for the
          // whole write cycle and hold afterwards.
          if (accept) begin
            memAddr <= addr_cnt;
            memData <= {data_hi, inData};
            state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          addr_cnt <= addr_cnt + ADDR_ONE;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  inData;
  logic        inValid;
  logic        inReady;
  logic        memWe;
  logic [8:0]  memAddr;
  logic [11:0] memData;
  logic        coreRst_n;
  logic        busy;
  logic        error;

  prog_loader #(.ADDR_WIDTH(9), .INST_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .inData(inData), .inValid(inValid), .inReady(inReady),
    .memWe(memWe), .memAddr(memAddr), .memData(memData),
    .coreRst_n(coreRst_n), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: payload bytes are gathered in a queue per frame; a
  // complete frame either loads the pointer or schedules one memory write.
  int         m_kind;      // 0: expecting a command, 1: address frame, 2: data frame
  logic [7:0] m_q[$];
  logic [8:0] m_ptr;
  logic       m_wpend;
  logic [8:0] m_addr;
  logic [11:0] m_data;
  logic       m_core;
  logic       m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_kind = 0; m_q.delete(); m_ptr = '0; m_wpend = 0;
    m_addr = '0; m_data = '0; m_core = 0; m_err = 0;
  endtask

  task automatic model_update(input logic r, input logic v, input logic [7:0] d);
    logic rdy;
    if (r) begin
      model_reset();
    end else begin
      rdy = !m_wpend;
      if (m_wpend) begin
        m_ptr   = m_ptr + 9'd1;
        m_wpend = 0;
      end
      if (v && rdy) begin
        if (m_kind != 0) begin
          m_q.push_back(d);
          if (m_q.size() == 2) begin
            if (m_kind == 1) begin
              m_ptr = {m_q[0][0], m_q[1]};
            end else begin
              m_addr  = m_ptr;
              m_data  = {m_q[0][3:0], m_q[1]};
              m_wpend = 1;
            end
            m_q.delete();
            m_kind = 0;
          end
        end else begin
          case (d)
            8'h01: if (m_core) m_err = 1; else m_kind = 1;
            8'h02: if (m_core) m_err = 1; else m_kind = 2;
            8'h03: m_core = 1;
            8'h04: begin m_core = 0; m_err = 0; end
            default: m_err = 1;
          endcase
        end
      end
    end
  endtask

  // One clock: drive inputs, clock, then compare every output to the model.
  task automatic step(input logic r, input logic v, input logic [7:0] d);
    rst = r; inValid = v; inData = d;
    @(posedge clk);
    #1;
    cyc++;
    model_update(r, v, d);
    chk("memWe",     32'(memWe),     32'(m_wpend));
    chk("inReady",   32'(inReady),   32'(!m_wpend));
    chk("busy",      32'(busy),      32'((m_kind != 0) || m_wpend));
    chk("memAddr",   32'(memAddr),   32'(m_addr));
    chk("memData",   32'(memData),   32'(m_data));
    chk("coreRst_n", 32'(coreRst_n), 32'(m_core));
    chk("error",     32'(error),     32'(m_err));
  endtask

  typedef struct {
    logic        r;
    logic        v;
    logic [7:0]  d;
    logic        we;
    logic [8:0]  addr;
    logic [11:0] data;
    logic        core;
    logic        err;
    logic        bsy;
    logic        rdy;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic v, input logic [7:0] d, input logic we,
                     input logic [8:0] addr, input logic [11:0] data, input logic core,
                     input logic err, input logic bsy, input logic rdy);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.we = we; t.addr = addr; t.data = data;
    t.core = core; t.err = err; t.bsy = bsy; t.rdy = rdy;
    vq.push_back(t);
  endtask

  logic [7:0] hold_bytes[6];

  initial begin
    int idx, cyc_used, we_seen, rdy_low;
    logic acc, r, v;
    logic [7:0] d;

    clk = 0; rst = 1; inValid = 0; inData = 8'h00;
    model_reset();

    // Expected outputs after each clock edge.
    //   r  v  data    we addr    data     core err busy rdy
    add(1, 0, 8'h00,  0, 9'h000, 12'h000, 0, 0, 0, 1);  // reset
    add(0, 1, 8'h01,  0, 9'h000, 12'h000, 0, 0, 1, 1);  // load addr 0x010
    add(0, 1, 8'h00,  0, 9'h000, 12'h000, 0, 0, 1, 1);
    add(0, 1, 8'h10,  0, 9'h000, 12'h000, 0, 0, 0, 1);
    add(0, 1, 8'h02,  0, 9'h000, 12'h000, 0, 0, 1, 1);  // write 0xABC
    add(0, 1, 8'h0A,  0, 9'h000, 12'h000, 0, 0, 1, 1);
    add(0, 1, 8'hBC,  1, 9'h010, 12'hABC, 0, 0, 1, 0);
    add(0, 0, 8'h00,  0, 9'h010, 12'hABC, 0, 0, 0, 1);
    add(0, 1, 8'h01,  0, 9'h010, 12'hABC, 0, 0, 1, 1);  // load addr 0x1FF
    add(0, 1, 8'h01,  0, 9'h010, 12'hABC, 0, 0, 1, 1);
    add(0, 1, 8'hFF,  0, 9'h010, 12'hABC, 0, 0, 0, 1);
    add(0, 1, 8'h02,  0, 9'h010, 12'hABC, 0, 0, 1, 1);  // 0x123 @ 0x1FF
    add(0, 1, 8'h01,  0, 9'h010, 12'hABC, 0, 0, 1, 1);
    add(0, 1, 8'h23,  1, 9'h1FF, 12'h123, 0, 0, 1, 0);
    add(0, 0, 8'h00,  0, 9'h1FF, 12'h123, 0, 0, 0, 1);
    add(0, 1, 8'h02,  0, 9'h1FF, 12'h123, 0, 0, 1, 1);  // 0x456 @ 0x000 (wrap)
    add(0, 1, 8'h04,  0, 9'h1FF, 12'h123, 0, 0, 1, 1);
    add(0, 1, 8'h56,  1, 9'h000, 12'h456, 0, 0, 1, 0);
    add(0, 0, 8'h00,  0, 9'h000, 12'h456, 0, 0, 0, 1);
    add(0, 1, 8'h03,  0, 9'h000, 12'h456, 1, 0, 0, 1);  // RUN
    add(0, 1, 8'h02,  0, 9'h000, 12'h456, 1, 1, 0, 1);  // WRITE while running
    add(0, 1, 8'h00,  0, 9'h000, 12'h456, 1, 1, 0, 1);  // illegal command
    add(0, 1, 8'h01,  0, 9'h000, 12'h456, 1, 1, 0, 1);  // LOAD while running
    add(0, 1, 8'h03,  0, 9'h000, 12'h456, 1, 1, 0, 1);  // RUN while running
    add(0, 1, 8'h04,  0, 9'h000, 12'h456, 0, 0, 0, 1);  // HALT clears error
    add(0, 1, 8'h7F,  0, 9'h000, 12'h456, 0, 1, 0, 1);  // illegal command
    add(0, 0, 8'h00,  0, 9'h000, 12'h456, 0, 1, 0, 1);  // sticky
    add(0, 1, 8'h04,  0, 9'h000, 12'h456, 0, 0, 0, 1);
    add(0, 1, 8'h04,  0, 9'h000, 12'h456, 0, 0, 0, 1);  // HALT while halted
    add(0, 1, 8'h02,  0, 9'h000, 12'h456, 0, 0, 1, 1);  // frame aborted by reset
    add(0, 1, 8'h0A,  0, 9'h000, 12'h456, 0, 0, 1, 1);
    add(1, 0, 8'h00,  0, 9'h000, 12'h000, 0, 0, 0, 1);
    add(1, 1, 8'hBC,  0, 9'h000, 12'h000, 0, 0, 0, 1);
    add(0, 1, 8'h01,  0, 9'h000, 12'h000, 0, 0, 1, 1);  // first byte is a command
    add(0, 1, 8'h00,  0, 9'h000, 12'h000, 0, 0, 1, 1);
    add(0, 1, 8'h05,  0, 9'h000, 12'h000, 0, 0, 0, 1);
    add(0, 1, 8'h02,  0, 9'h000, 12'h000, 0, 0, 1, 1);
    add(0, 1, 8'h00,  0, 9'h000, 12'h000, 0, 0, 1, 1);
    add(0, 1, 8'h07,  1, 9'h005, 12'h007, 0, 0, 1, 0);
    add(0, 0, 8'h00,  0, 9'h005, 12'h007, 0, 0, 0, 1);
    add(0, 1, 8'h01,  0, 9'h005, 12'h007, 0, 0, 1, 1);  // upper address bits ignored
    add(0, 1, 8'hFE,  0, 9'h005, 12'h007, 0, 0, 1, 1);
    add(0, 1, 8'h33,  0, 9'h005, 12'h007, 0, 0, 0, 1);
    add(0, 1, 8'h02,  0, 9'h005, 12'h007, 0, 0, 1, 1);  // upper word bits ignored
    add(0, 1, 8'hFA,  0, 9'h005, 12'h007, 0, 0, 1, 1);
    add(0, 1, 8'hBC,  1, 9'h033, 12'hABC, 0, 0, 1, 0);
    add(0, 0, 8'h00,  0, 9'h033, 12'hABC, 0, 0, 0, 1);

    foreach (vq[i]) begin
      step(vq[i].r, vq[i].v, vq[i].d);
      chk("vec_memWe",     32'(memWe),     32'(vq[i].we));
      chk("vec_memAddr",   32'(memAddr),   32'(vq[i].addr));
      chk("vec_memData",   32'(memData),   32'(vq[i].data));
      chk("vec_coreRst_n", 32'(coreRst_n), 32'(vq[i].core));
      chk("vec_error",     32'(error),     32'(vq[i].err));
      chk("vec_busy",      32'(busy),      32'(vq[i].bsy));
      chk("vec_inReady",   32'(inReady),   32'(vq[i].rdy));
    end

    // Back-to-back frames with inValid held high: each byte is held until it
    // is taken, so two writes need 7 cycles with inReady low only in WRITE.
    hold_bytes[0] = 8'h02; hold_bytes[1] = 8'h01; hold_bytes[2] = 8'h11;
    hold_bytes[3] = 8'h02; hold_bytes[4] = 8'h02; hold_bytes[5] = 8'h22;
    idx = 0; cyc_used = 0; we_seen = 0; rdy_low = 0;
    while (idx < 6 && cyc_used < 20) begin
      acc = !m_wpend;
      step(0, 1, hold_bytes[idx]);
      if (acc) idx++;
      cyc_used++;
      if (memWe) we_seen++;
      if (!inReady) rdy_low++;
    end
    chk("hold_all_bytes_taken", 32'(idx), 32'd6);
    chk("hold_cycles", 32'(cyc_used), 32'd7);
    chk("hold_write_count", 32'(we_seen), 32'd2);
    chk("hold_ready_low_cycles", 32'(rdy_low), 32'd2);
    chk("hold_last_addr", 32'(memAddr), 32'h035);
    chk("hold_last_data", 32'(memData), 32'h222);
    step(0, 0, 8'h00);

    // Randomized traffic against the model, biased toward legal commands.
    for (int k = 0; k < 4000; k++) begin
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 6) d = 8'($urandom_range(1, 4));
      else                          d = 8'($urandom_range(0, 255));
      step(r, v, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 9, program-memory address width (matches PC width).
REQ-002 Parameter INST_WIDTH, default 12, instruction word width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 inData  input  8  command/payload byte stream.
REQ-006 inValid  input  1  inData is valid this cycle.
REQ-007 inReady  output  1  loader can accept a byte this cycle.
REQ-008 memWe  output  1  program-memory write strobe, one cycle per word.
REQ-009 memAddr  output  ADDR_WIDTH  program-memory write address.
REQ-010 memData  output  INST_WIDTH  program-memory write data.
REQ-011 coreRst_n  output  1  active-low reset to the CPU core; 0 holds the core.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 error  output  1  sticky protocol-error flag.

Function
REQ-014 A byte SHALL be accepted only on a cycle with inValid=1 and inReady=1; inReady SHALL be 1 in every state except WRITE.
REQ-015 States SHALL be IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO and WRITE.
REQ-016 In IDLE, an accepted byte is a command: 0x01 LOAD_ADDR -> ADDR_HI; 0x02 WRITE -> DATA_HI; 0x03 RUN; 0x04 HALT; any other value SHALL set error and leave the state at IDLE.
REQ-017 ADDR_HI SHALL capture inData[ADDR_WIDTH-9:0] as the address MSBs, ignore the remaining bits, and go to ADDR_LO.
REQ-018 ADDR_LO SHALL capture inData as address bits [7:0], load the address counter, and return to IDLE.
REQ-019 DATA_HI SHALL capture inData[INST_WIDTH-9:0] as the word MSBs, ignore the remaining bits, and go to DATA_LO.
REQ-020 DATA_LO SHALL capture inData[7:0] as the word LSBs and go to WRITE.
REQ-021 WRITE SHALL last exactly one cycle, with memWe=1, memAddr=address counter and memData=assembled word, then return to IDLE.
REQ-022 The address counter SHALL increment by one on the cycle after WRITE and wrap from 2^ADDR_WIDTH-1 to 0.
REQ-023 memAddr and memData SHALL be registered and hold their last values when memWe=0.
REQ-024 RUN SHALL set coreRst_n to 1 on the cycle after acceptance; HALT SHALL clear coreRst_n to 0 and clear error on the cycle after acceptance.
REQ-025 LOAD_ADDR or WRITE accepted while coreRst_n=1 SHALL set error, be consumed without a state change, and cause no memory write.
REQ-026 RUN while already running, or HALT while already halted, SHALL have no effect other than HALT clearing error.
REQ-027 error SHALL stay set until HALT or reset.
REQ-028 There SHALL be no timeout: the FSM waits indefinitely between payload bytes.
REQ-029 Minimum spacing between consecutive WRITE frames SHALL be 4 cycles (3 accepted bytes plus 1 WRITE cycle).

Reset
REQ-030 While rst=1: state=IDLE, address counter=0, memAddr=0, memData=0, memWe=0, coreRst_n=0, busy=0, error=0, inReady=1.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no write, and the first byte after reset release SHALL be decoded as a command.

Verification
REQ-032 Reset, then send 01 00 10 02 0A BC -> exactly one memWe pulse, memAddr=0x010, memData=0xABC, then address counter=0x011.
REQ-033 Send 01 01 FF, then 02 01 23 and 02 04 56 -> writes 0x123@0x1FF and 0x456@0x000 (wrap).
REQ-034 Send 03, then 02 00 01 -> coreRst_n=1 one cycle after 03; error=1; no memWe; the bytes 00 and 01 are decoded as commands (00 is illegal and keeps error set); coreRst_n remains 1.
REQ-035 Send 7F -> error=1, state IDLE; then 04 -> error=0, coreRst_n=0.
REQ-036 Assert rst after 02 0A -> no memWe; after release, 01 00 05 loads address 0x005; all outputs at reset values during rst.
REQ-037 Hold inValid=1 through a full write frame -> inReady=0 only in the WRITE cycle, and no byte is lost or duplicated.
